// File: rtl/glyph_line_fetcher_if.sv
// Glyph ROM access bus: the fetcher drives digit/row selects and the ROM
// answers combinationally with the 5-bit row pattern in the same cycle.
interface glyph_line_fetcher_if;
    logic [3:0] rom_digit;
    logic [2:0] rom_row;
    logic [4:0] rom_code;

    modport master (output rom_digit, output rom_row, input rom_code);
    modport slave  (input rom_digit, input rom_row, output rom_code);
endinterface

// File: rtl/glyph_line_fetcher.sv
// Renders a NUM_DIGITS-wide numeric field from a shared 5x6 glyph ROM: fetches one
// glyph row per digit into a line buffer during h-blank, then serialises it per pixel.
module glyph_line_fetcher #(
    parameter int NUM_DIGITS = 8,
    parameter int X0         = 16,
    parameter int Y0         = 16,
    parameter int GLYPH_H    = 6,
    parameter int CHAR_PITCH = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic                      line_start,
    input  logic [9:0]                next_line,
    glyph_line_fetcher_if.master      rom,
    input  logic                      pix_en,
    input  logic                      video_on,
    input  logic [9:0]                pixel_x,
    output logic                      pixel_on,
    output logic                      busy
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int COL_W = $clog2(CHAR_PITCH);

    localparam logic [10:0]      Y_LO      = 11'(Y0);
    localparam logic [10:0]      Y_HI      = 11'(Y0 + GLYPH_H);
    localparam logic [10:0]      X_LO      = 11'(X0);
    localparam logic [10:0]      X_HI      = 11'(X0 + NUM_DIGITS * CHAR_PITCH);
    localparam logic [2:0]       Y0_LOW3   = 3'(Y0);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(CHAR_PITCH - 1);
    localparam logic [COL_W-1:0] COL_GLYPH = COL_W'(5);

    typedef enum logic [0:0] {IDLE = 1'b0, FETCH = 1'b1} state_t;

    state_t                       state_r;
    logic [IDX_W-1:0]             idx_r;
    logic [NUM_DIGITS-1:0][3:0]   snap_r;
    logic [NUM_DIGITS-1:0][4:0]   buf_r;
    logic                         in_band_r;
    logic [2:0]                   row_r;
    logic [COL_W-1:0]             col_r;
    logic [IDX_W-1:0]             pos_r;

    logic                         in_band_s;
    logic [2:0]                   row_s;
    logic [4:0]                   wr_code_s;
    logic [IDX_W-1:0]             idx_nxt_s;
    logic                         px_active_s;
    logic                         at_x0_s;
    logic [COL_W-1:0]             eff_col_s;
    logic [IDX_W-1:0]             eff_pos_s;
    logic [2:0]                   bit_sel_s;
    logic                         glyph_bit_s;
    logic [COL_W-1:0]             col_nxt_s;
    logic [IDX_W-1:0]             pos_nxt_s;

    // Line qualification and buffer write data for the current fetch slot
    always_comb begin
        in_band_s = ({1'b0, next_line} >= Y_LO) && ({1'b0, next_line} < Y_HI);
        row_s     = next_line[2:0] - Y0_LOW3;
        idx_nxt_s = idx_r + IDX_W'(1);
        if (in_band_r && (snap_r[idx_r] <= 4'd9)) begin
            wr_code_s = rom.rom_code;
        end else begin
            wr_code_s = 5'd0;
        end
    end

    // Fetch sequencer: line_start always (re)starts a fetch from slot 0
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            idx_r         <= {IDX_W{1'b0}};
            snap_r        <= {(4*NUM_DIGITS){1'b0}};
            buf_r         <= {(5*NUM_DIGITS){1'b0}};
            in_band_r     <= 1'b0;
            row_r         <= 3'd0;
            busy          <= 1'b0;
            rom.rom_digit <= 4'd0;
            rom.rom_row   <= 3'd0;
        end else if (line_start) begin
            state_r       <= FETCH;
            idx_r         <= {IDX_W{1'b0}};
            snap_r        <= digits_in;
            in_band_r     <= in_band_s;
            row_r         <= row_s;
            busy          <= 1'b1;
            rom.rom_digit <= digits_in[3:0];
            rom.rom_row   <= row_s;
        end else begin
            case (state_r)
                IDLE: begin
                    busy <= 1'b0;
                end
                FETCH: begin
                    buf_r[idx_r] <= wr_code_s;
                    if (idx_r == IDX_LAST) begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        // Selects are registered, so present the next slot one cycle ahead
                        idx_r         <= idx_nxt_s;
                        rom.rom_digit <= snap_r[idx_nxt_s];
                        rom.rom_row   <= row_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Pixel column/position tracking and glyph bit selection
    always_comb begin
        px_active_s = video_on && ({1'b0, pixel_x} >= X_LO) && ({1'b0, pixel_x} < X_HI);
        at_x0_s     = ({1'b0, pixel_x} == X_LO);
        if (at_x0_s) begin
            eff_col_s = {COL_W{1'b0}};
            eff_pos_s = {IDX_W{1'b0}};
        end else begin
            eff_col_s = col_r;
            eff_pos_s = pos_r;
        end
        bit_sel_s = 3'd4 - 3'(eff_col_s);
        if (eff_col_s < COL_GLYPH) begin
            glyph_bit_s = buf_r[eff_pos_s][bit_sel_s];
        end else begin
            glyph_bit_s = 1'b0;
        end
        if (eff_col_s == COL_LAST) begin
            col_nxt_s = {COL_W{1'b0}};
            if (eff_pos_s == IDX_LAST) begin
                pos_nxt_s = {IDX_W{1'b0}};
            end else begin
                pos_nxt_s = eff_pos_s + IDX_W'(1);
            end
        end else begin
            col_nxt_s = eff_col_s + COL_W'(1);
            pos_nxt_s = eff_pos_s;
        end
    end

    // Pixel output register; everything holds while pix_en is low
    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_on <= 1'b0;
            col_r    <= {COL_W{1'b0}};
            pos_r    <= {IDX_W{1'b0}};
        end else if (pix_en) begin
            if (px_active_s) begin
                pixel_on <= glyph_bit_s;
                col_r    <= col_nxt_s;
                pos_r    <= pos_nxt_s;
            end else begin
                pixel_on <= 1'b0;
                if (at_x0_s) begin
                    col_r <= {COL_W{1'b0}};
                    pos_r <= {IDX_W{1'b0}};
                end
            end
        end
    end

endmodule

// File: tb/tb_glyph_line_fetcher.sv
// Self-checking bench for glyph_line_fetcher: a pixel-coordinate model of the field
// is compared against pixel_on every cycle, backed by hand-computed directed checks.
module tb_glyph_line_fetcher;

    localparam int N  = 8;
    localparam int X0 = 16;
    localparam int Y0 = 16;

    logic        clk = 1'b0;
    logic        reset, line_start, pix_en, video_on;
    logic [31:0] digits_in;
    logic [9:0]  next_line, pixel_x;
    logic        pixel_on, busy;
    int          checks = 0;
    int          failures = 0;
    logic        chk_en = 1'b0;

    always #5 clk = ~clk;

    glyph_line_fetcher_if rom_if ();

    glyph_line_fetcher #(
        .NUM_DIGITS(N), .X0(X0), .Y0(Y0), .GLYPH_H(6), .CHAR_PITCH(6)
    ) dut (
        .clk(clk), .reset(reset), .digits_in(digits_in), .line_start(line_start),
        .next_line(next_line), .rom(rom_if), .pix_en(pix_en), .video_on(video_on),
        .pixel_x(pixel_x), .pixel_on(pixel_on), .busy(busy)
    );

    // Reference 5x6 font; unused codes and rows answer all-ones to expose missing blanking
    function automatic logic [4:0] glyph(input logic [3:0] d, input logic [2:0] r);
        logic [29:0] g;
        int          ri;
        case (d)
            4'd0: g = 30'b01110_10001_10011_10101_11001_01110;
            4'd1: g = 30'b00100_01100_00100_00100_00100_01110;
            4'd2: g = 30'b01110_10001_00010_00100_01000_11111;
            4'd3: g = 30'b11110_00001_01110_00001_00001_11110;
            4'd4: g = 30'b00010_00110_01010_11111_00010_00010;
            4'd5: g = 30'b11111_10000_11110_00001_00001_11110;
            4'd6: g = 30'b01110_10000_11110_10001_10001_01110;
            4'd7: g = 30'b11111_00001_00010_00100_01000_01000;
            4'd8: g = 30'b01110_10001_01110_10001_10001_01110;
            4'd9: g = 30'b01110_10001_01111_00001_00001_01110;
            default: g = {30{1'b1}};
        endcase
        ri = int'(r);
        if (ri > 5) return 5'b11111;
        return g[29 - 5*ri -: 5];
    endfunction

    always_comb rom_if.rom_code = glyph(rom_if.rom_digit, rom_if.rom_row);

    // Expected pixel at screen column x for a line rendered from digits dg at scanline ln
    function automatic logic model_px(input logic [9:0] x, input logic [31:0] dg, input logic [9:0] ln);
        int         off, p, c, li, xi;
        logic [3:0] d;
        logic [4:0] bits;
        li = int'(ln);
        xi = int'(x);
        if (li < Y0 || li >= Y0 + 6) return 1'b0;
        if (xi < X0 || xi >= X0 + 6*N) return 1'b0;
        off  = xi - X0;
        p    = off / 6;
        c    = off % 6;
        d    = dg[4*p +: 4];
        if (c == 5 || d > 4'd9) return 1'b0;
        bits = glyph(d, 3'(li - Y0));
        return bits[4 - c];
    endfunction

    logic [31:0] m_digits;
    logic [9:0]  m_line;
    logic        exp_pix;

    always @(posedge clk) begin
        if (reset) begin
            m_digits <= 32'd0;
            m_line   <= 10'h3FF;
            exp_pix  <= 1'b0;
        end else begin
            if (line_start) begin
                m_digits <= digits_in;
                m_line   <= next_line;
            end
            if (pix_en) exp_pix <= video_on && model_px(pixel_x, m_digits, m_line);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) check("pixel_stream", {63'd0, pixel_on}, {63'd0, exp_pix});
    end

    task automatic start_line(input int ln);
        next_line  = 10'(ln);
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (!busy) break;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic sweep(input int xs, input int n, input int pause_at, output logic [63:0] bits);
        bits     = 64'd0;
        video_on = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (i == pause_at) begin
                pix_en = 1'b0;
                repeat (5) @(negedge clk);
            end
            pixel_x = 10'(xs + i);
            pix_en  = 1'b1;
            @(negedge clk);
            bits = {bits[62:0], pixel_on};
        end
        pix_en   = 1'b0;
        video_on = 1'b0;
        @(negedge clk);
    endtask

    logic [63:0] bits;
    int          n;

    initial begin
        reset = 1'b1; line_start = 1'b0; pix_en = 1'b0; video_on = 1'b0;
        digits_in = 32'd0; next_line = 10'd0; pixel_x = 10'd0;
        repeat (3) @(negedge clk);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_pixel_on", {63'd0, pixel_on}, 64'd0);
        check("reset_rom_digit", {60'd0, rom_if.rom_digit}, 64'd0);
        check("reset_rom_row", {61'd0, rom_if.rom_row}, 64'd0);
        reset  = 1'b0;
        chk_en = 1'b1;

        // Row 0 of a 6 in the leftmost position
        digits_in = 32'h98765436;
        start_line(Y0);
        check("first_rom_digit", {60'd0, rom_if.rom_digit}, 64'd6);
        check("first_rom_row", {61'd0, rom_if.rom_row}, 64'd0);
        check("first_busy", {63'd0, busy}, 64'd1);
        wait_idle(n);
        check("busy_len", 64'(n), 64'd8);
        sweep(X0, 6, -1, bits);
        check("row0_digit6", bits, 64'b011100);
        sweep(X0 - 2, 6*N + 4, -1, bits);
        sweep(X0, 3, -1, bits);
        check("pre_reset_pixel", {63'd0, pixel_on}, 64'd1);

        // Reset four cycles into a fetch
        start_line(Y0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midfetch_reset_busy", {63'd0, busy}, 64'd0);
        check("midfetch_reset_pixel", {63'd0, pixel_on}, 64'd0);
        check("midfetch_reset_digit", {60'd0, rom_if.rom_digit}, 64'd0);
        sweep(X0, 6*N, -1, bits);
        check("after_reset_field", bits, 64'd0);

        // Row 3 and out-of-band lines
        start_line(Y0 + 3);
        check("row3_rom_row", {61'd0, rom_if.rom_row}, 64'd3);
        wait_idle(n);
        sweep(X0, 6, -1, bits);
        check("row3_digit6", bits, 64'b100010);
        start_line(Y0 + 6);
        wait_idle(n);
        sweep(X0, 6*N, -1, bits);
        check("below_band", bits, 64'd0);
        start_line(Y0 - 1);
        wait_idle(n);
        sweep(X0, 6*N, -1, bits);
        check("above_band", bits, 64'd0);

        // Blank code in position 1
        digits_in = 32'h666666B6;
        start_line(Y0);
        wait_idle(n);
        sweep(X0, 12, -1, bits);
        check("blank_pos1", bits, 64'b011100_000000);

        // Restart three cycles into a fetch
        digits_in  = 32'h98765436;
        next_line  = 10'(Y0 + 3);
        line_start = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n += int'(busy);
            if (i == 0) line_start = 1'b0;
            if (i == 2) begin
                line_start = 1'b1;
                next_line  = 10'(Y0);
            end
            if (i == 3) line_start = 1'b0;
        end
        check("restart_busy_len", 64'(n), 64'd11);
        sweep(X0, 6, -1, bits);
        check("restart_second_line", bits, 64'b011100);

        // Snapshot isolation and a pix_en stall mid-field
        digits_in = 32'h98765446;
        start_line(Y0);
        @(negedge clk);
        digits_in = 32'h11111111;
        wait_idle(n);
        sweep(X0, 12, 4, bits);
        check("snapshot_and_stall", bits, 64'b011100_000100);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
